axi_lite_irq_ctrl: RTL and testbench

- Parametrised interrupt controller for the SoC peripheral interconnect. Supersedes the fixed 7-input intc.
- Source count is configurable. Each source has a runtime level/rising-edge mode, so pulse interrupts such as emaclite no longer depend on bit position.
- Adds enable set/clear aliases, W1C pending, software trigger and a lowest-index claim register, all behind an AXI4-Lite slave.
- Drives the single CPU interrupt line plus an encoded source ID.

---
 rtl/axi_lite_irq_ctrl_if.sv | 42 ++++
 rtl/axi_lite_irq_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_lite_irq_ctrl.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_lite_irq_ctrl_if
// AXI4-Lite bus bundle for the interrupt controller register slave.
//   master modport : drives AW/W/AR channels and B/R ready (CPU side)
//   slave  modport : drives AW/W/AR ready and the B/R response channels
// Signal names keep the s_ prefix of the controller's slave port list.
// ---------------------------------------------------------------------------
interface axi_lite_irq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_irq_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_irq_ctrl
// Parametrised interrupt controller with an AXI4-Lite register slave.
// Each source is synchronised, then latched into PENDING either as a level
// (follows the synchronised input) or as a rising edge (sticky until W1C).
// The lowest-index pending-and-enabled source drives the CPU line and ID.
//
// Ports:
//   aclk      : clock
//   areset    : synchronous reset, active-high
//   irq_i     : NUM_IRQ raw interrupt sources, asynchronous to aclk
//   irq_o     : registered CPU interrupt, |(pending & enable)
//   irq_id_o  : registered (lowest pending-and-enabled index)+1, 0 = none
//   s_axi     : AXI4-Lite slave (axi_lite_irq_ctrl_if.slave)
//
// Register map (addr[4:2]; addr[ADDR_W-1:5] != 0 is unmapped -> SLVERR):
//   0x00 STATUS RO, 0x04 PENDING RO/W1C(edge bits), 0x08 ENABLE RW,
//   0x0C MODE RW (1 = edge), 0x10 ENABLE_SET W1S, 0x14 ENABLE_CLR W1C,
//   0x18 CLAIM RO, 0x1C SW_TRIG W1S (edge bits only).
// ---------------------------------------------------------------------------
module axi_lite_irq_ctrl #(
  parameter int          NUM_IRQ      = 7,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] DEFAULT_MODE = 32'h0000_0001,
  parameter int          ADDR_W       = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                irq_o,
  output logic [5:0]          irq_id_o,
  axi_lite_irq_ctrl_if.slave  s_axi
);

  localparam logic [2:0] OFS_STATUS  = 3'd0;
  localparam logic [2:0] OFS_PENDING = 3'd1;
  localparam logic [2:0] OFS_ENABLE  = 3'd2;
  localparam logic [2:0] OFS_MODE    = 3'd3;
  localparam logic [2:0] OFS_EN_SET  = 3'd4;
  localparam logic [2:0] OFS_EN_CLR  = 3'd5;
  localparam logic [2:0] OFS_CLAIM   = 3'd6;
  localparam logic [2:0] OFS_SW_TRIG = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Expand byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // Lowest set index + 1, or 0 when the vector is empty. Scanning from the
  // top down lets the lowest index overwrite any higher one.
  function automatic logic [5:0] prio_id(input logic [NUM_IRQ-1:0] vec);
    logic [5:0] id;
    id = 6'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      id = vec[i] ? 6'(i + 1) : id;
    end
    return id;
  endfunction

  // State
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic               irq_q, irq_d;
  logic [5:0]         irq_id_q, irq_id_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [31:0]        rdata_q, rdata_d;

  // Combinational helpers
  logic [NUM_IRQ-1:0] sync_s;
  logic [ADDR_W-1:0]  aw_addr_s, ar_addr_s;
  logic               w_hs_s, r_hs_s;
  logic               w_unmapped_s, r_unmapped_s;
  logic               w_do_s;
  logic [31:0]        be_mask_s, wdata_m_s;
  logic [NUM_IRQ-1:0] wr_bits_s, wr_keep_s;
  logic [NUM_IRQ-1:0] pend_clr_s, sw_set_s, mode_chg_s, edge_set_s;
  logic [31:0]        rd_val_s;
  logic               unused_s;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign aw_addr_s = s_axi.s_awaddr;
  assign ar_addr_s = s_axi.s_araddr;

  // Handshakes complete on the edge where the registered ready meets valid.
  assign w_hs_s       = awready_q & wready_q & s_axi.s_awvalid & s_axi.s_wvalid;
  assign r_hs_s       = arready_q & s_axi.s_arvalid;
  assign w_unmapped_s = |(aw_addr_s >> 3'd5);
  assign r_unmapped_s = |(ar_addr_s >> 3'd5);
  assign w_do_s       = w_hs_s & ~w_unmapped_s;

  // Masked bytes behave as zeros for W1S/W1C and as "keep" for RW fields.
  assign be_mask_s = strb_to_mask(s_axi.s_wstrb);
  assign wdata_m_s = s_axi.s_wdata & be_mask_s;
  assign wr_bits_s = wdata_m_s[NUM_IRQ-1:0];
  assign wr_keep_s = be_mask_s[NUM_IRQ-1:0];

  // Address LSBs and data bits above NUM_IRQ carry no meaning here.
  assign unused_s = ^{aw_addr_s[1:0], ar_addr_s[1:0], wdata_m_s, be_mask_s};

  // Input synchroniser shift chain and one-cycle history for edge detect.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = sync_s;
  end

  // Register-file write decode for ENABLE/MODE and the pending side-effects.
  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    pend_clr_s = '0;
    sw_set_s   = '0;
    if (w_do_s) begin
      case (aw_addr_s[4:2])
        OFS_PENDING: pend_clr_s = wr_bits_s;
        OFS_ENABLE:  enable_d   = (enable_q & ~wr_keep_s) | wr_bits_s;
        OFS_MODE:    mode_d     = (mode_q & ~wr_keep_s) | wr_bits_s;
        OFS_EN_SET:  enable_d   = enable_q | wr_bits_s;
        OFS_EN_CLR:  enable_d   = enable_q & ~wr_bits_s;
        OFS_SW_TRIG: sw_set_s   = wr_bits_s;
        default:     enable_d   = enable_q;  // STATUS / CLAIM are read-only
      endcase
    end else begin
      enable_d = enable_q;
      mode_d   = mode_q;
    end
  end

  // Pending update: a mode change wins and clears, otherwise level bits
  // follow the synchronised input and edge bits are sticky with set
  // taking priority over a same-cycle W1C.
  always_comb begin
    mode_chg_s = mode_d ^ mode_q;
    edge_set_s = (sync_s & ~prev_q) | sw_set_s;
    pend_d     = ~mode_chg_s &
                 ((~mode_q & sync_s) |
                  ( mode_q & (edge_set_s | (pend_q & ~pend_clr_s))));
  end

  // CPU-facing interrupt line and encoded source ID.
  always_comb begin
    irq_d    = |(pend_q & enable_q);
    irq_id_d = prio_id(pend_q & enable_q);
  end

  // Read data mux; write-only aliases read as zero.
  always_comb begin
    rd_val_s = 32'd0;
    case (ar_addr_s[4:2])
      OFS_STATUS:  rd_val_s = 32'(sync_s);
      OFS_PENDING: rd_val_s = 32'(pend_q);
      OFS_ENABLE:  rd_val_s = 32'(enable_q);
      OFS_MODE:    rd_val_s = 32'(mode_q);
      OFS_CLAIM:   rd_val_s = 32'(irq_id_q);
      default:     rd_val_s = 32'd0;
    endcase
  end

  // Write channel: single-cycle ready pulse, response held until bready.
  always_comb begin
    awready_d = s_axi.s_awvalid & s_axi.s_wvalid & ~bvalid_q & ~awready_q;
    wready_d  = awready_d;
    if (w_hs_s) begin
      bvalid_d = 1'b1;
      bresp_d  = w_unmapped_s ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && s_axi.s_bready) begin
      bvalid_d = 1'b0;
      bresp_d  = bresp_q;
    end else begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
    end
  end

  // Read channel: data captured from pre-update state at the accept edge.
  always_comb begin
    arready_d = s_axi.s_arvalid & ~rvalid_q & ~arready_q;
    if (r_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = r_unmapped_s ? 32'd0 : rd_val_s;
      rresp_d  = r_unmapped_s ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axi.s_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end else begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      mode_q    <= DEFAULT_MODE[NUM_IRQ-1:0];
      irq_q     <= 1'b0;
      irq_id_q  <= 6'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'd0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_o           = irq_q;
  assign irq_id_o        = irq_id_q;
  assign s_axi.s_awready = awready_q;
  assign s_axi.s_wready  = wready_q;
  assign s_axi.s_bvalid  = bvalid_q;
  assign s_axi.s_bresp   = bresp_q;
  assign s_axi.s_arready = arready_q;
  assign s_axi.s_rvalid  = rvalid_q;
  assign s_axi.s_rresp   = rresp_q;
  assign s_axi.s_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_irq_ctrl
// Self-checking bench for axi_lite_irq_ctrl (NUM_IRQ=7, SYNC_STAGES=2).
// Expected register contents come from a small transaction-level model
// (m_enable / m_mode) and from plain arithmetic on the driven patterns.
// ---------------------------------------------------------------------------
module tb_axi_lite_irq_ctrl;

  localparam int          NUM_IRQ     = 7;
  localparam int          SYNC_STAGES = 2;
  localparam int          ADDR_W      = 8;
  localparam int          LAT         = SYNC_STAGES + 2;
  localparam logic [31:0] IRQ_MASK    = 32'h0000_007F;

  localparam logic [7:0] A_STATUS  = 8'h00;
  localparam logic [7:0] A_PENDING = 8'h04;
  localparam logic [7:0] A_ENABLE  = 8'h08;
  localparam logic [7:0] A_MODE    = 8'h0C;
  localparam logic [7:0] A_EN_SET  = 8'h10;
  localparam logic [7:0] A_EN_CLR  = 8'h14;
  localparam logic [7:0] A_CLAIM   = 8'h18;
  localparam logic [7:0] A_SW_TRIG = 8'h1C;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NUM_IRQ-1:0] irq_i;
  logic               irq_o;
  logic [5:0]         irq_id_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_enable;
  logic [31:0] m_mode;

  axi_lite_irq_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  axi_lite_irq_ctrl #(
    .NUM_IRQ     (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES),
    .DEFAULT_MODE(32'h0000_0001),
    .ADDR_W      (ADDR_W)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .irq_i   (irq_i),
    .irq_o   (irq_o),
    .irq_id_o(irq_id_o),
    .s_axi   (ifc)
  );

  always #5 aclk = ~aclk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m = m | (32'h0000_00FF << (8 * b));
    end
    return m;
  endfunction

  function automatic logic [5:0] lowest_id(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) return 6'(i + 1);
    end
    return 6'd0;
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    ifc.s_awaddr  = addr;
    ifc.s_wdata   = data;
    ifc.s_wstrb   = strb;
    ifc.s_awvalid = 1'b1;
    ifc.s_wvalid  = 1'b1;
    ifc.s_bready  = 1'b1;
    n = 0;
    while (ifc.s_awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ifc.s_awready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL write_accept_timeout addr=%h: awready=%b required 1", addr, ifc.s_awready);
    end
    tick();
    ifc.s_awvalid = 1'b0;
    ifc.s_wvalid  = 1'b0;
    resp = ifc.s_bresp;
    if (ifc.s_bvalid !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL write_bvalid addr=%h: bvalid=%b required 1", addr, ifc.s_bvalid);
    end
    tick();
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    ifc.s_araddr  = addr;
    ifc.s_arvalid = 1'b1;
    ifc.s_rready  = 1'b1;
    n = 0;
    while (ifc.s_arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ifc.s_arready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL read_accept_timeout addr=%h: arready=%b required 1", addr, ifc.s_arready);
    end
    tick();
    ifc.s_arvalid = 1'b0;
    data = ifc.s_rdata;
    resp = ifc.s_rresp;
    if (ifc.s_rvalid !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL read_rvalid addr=%h: rvalid=%b required 1", addr, ifc.s_rvalid);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp_d;
    areset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({irq_o, irq_id_o} !== 7'd0) begin
      n_errors++; $display("FAIL reset_irq: got irq=%b id=%0d required 0/0", irq_o, irq_id_o);
    end
    n_checks++;
    if ({ifc.s_awready, ifc.s_wready, ifc.s_arready, ifc.s_bvalid, ifc.s_rvalid} !== 5'd0) begin
      n_errors++; $display("FAIL reset_handshake: got %b required 00000",
        {ifc.s_awready, ifc.s_wready, ifc.s_arready, ifc.s_bvalid, ifc.s_rvalid});
    end
    areset = 1'b0;
    tick();
    m_enable = 32'd0;
    m_mode   = 32'h0000_0001;
    for (int a = 0; a < 8; a++) begin
      axi_read(8'(a * 4), d, r);
      exp_d = (a == 3) ? 32'h0000_0001 : 32'd0;
      n_checks++;
      if (d !== exp_d) begin
        n_errors++; $display("FAIL reset_read_%0d: got %h required %h", a, d, exp_d);
      end
      n_checks++;
      if (r !== 2'b00) begin
        n_errors++; $display("FAIL reset_rresp_%0d: got %b required 00", a, r);
      end
    end
  endtask

  task automatic test_reg_random();
    logic [31:0] d, data, m;
    logic [1:0]  r;
    logic [3:0]  strb;
    logic [7:0]  addr;
    int          sel;
    for (int it = 0; it < 24; it++) begin
      sel  = int'($urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      m    = byte_mask(strb);
      case (sel)
        0: begin addr = A_ENABLE; m_enable = (m_enable & ~m) | (data & m); end
        1: begin addr = A_MODE;   m_mode   = (m_mode & ~m) | (data & m); end
        2: begin addr = A_EN_SET; m_enable = m_enable | (data & m); end
        default: begin addr = A_EN_CLR; m_enable = m_enable & ~(data & m); end
      endcase
      m_enable = m_enable & IRQ_MASK;
      m_mode   = m_mode & IRQ_MASK;
      axi_write(addr, data, strb, r);
      n_checks++;
      if (r !== 2'b00) begin
        n_errors++; $display("FAIL regs_bresp it=%0d: got %b required 00", it, r);
      end
      axi_read(A_ENABLE, d, r);
      n_checks++;
      if (d !== m_enable) begin
        n_errors++; $display("FAIL regs_enable it=%0d: got %h required %h", it, d, m_enable);
      end
      axi_read(A_MODE, d, r);
      n_checks++;
      if (d !== m_mode) begin
        n_errors++; $display("FAIL regs_mode it=%0d: got %h required %h", it, d, m_mode);
      end
    end
  endtask

  task automatic test_edge_pulse();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(A_MODE, 32'h1, 4'hF, r);   m_mode = 32'h1;
    axi_write(A_ENABLE, 32'h7F, 4'hF, r); m_enable = 32'h7F;
    irq_i[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      irq_i[0] = 1'b0;
      n_checks++;
      if (irq_o !== (k == LAT)) begin
        n_errors++; $display("FAIL pulse_latency cycle=%0d: irq_o=%b required %b", k, irq_o, (k == LAT));
      end
    end
    n_checks++;
    if (irq_id_o !== 6'd1) begin
      n_errors++; $display("FAIL pulse_id: got %0d required 1", irq_id_o);
    end
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_errors++; $display("FAIL pulse_pending: got %h required 00000001", d);
    end
    axi_read(A_CLAIM, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_errors++; $display("FAIL pulse_claim: got %h required 00000001", d);
    end
    axi_write(A_PENDING, 32'h1, 4'hF, r);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_errors++; $display("FAIL pulse_w1c_irq: got %b required 0", irq_o);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic [1:0]  r;
    irq_i[3] = 1'b1;
    repeat (LAT) tick();
    n_checks++;
    if (irq_o !== 1'b1 || irq_id_o !== 6'd4) begin
      n_errors++; $display("FAIL level_assert: irq=%b id=%0d required 1/4", irq_o, irq_id_o);
    end
    axi_write(A_PENDING, 32'h08, 4'hF, r);
    repeat (2) tick();
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h08) begin
      n_errors++; $display("FAIL level_w1c_ignored: got %h required 00000008", d);
    end
    irq_i[3] = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      n_checks++;
      if (irq_o !== (k < LAT)) begin
        n_errors++; $display("FAIL level_drop cycle=%0d: irq_o=%b required %b", k, irq_o, (k < LAT));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0]  r;
    // Align the W1C accept edge with the edge that latches the rising input.
    irq_i[0] = 1'b1;
    repeat (SYNC_STAGES - 1) tick();
    ifc.s_awaddr  = A_PENDING;
    ifc.s_wdata   = 32'h1;
    ifc.s_wstrb   = 4'hF;
    ifc.s_bready  = 1'b1;
    ifc.s_awvalid = 1'b1;
    ifc.s_wvalid  = 1'b1;
    tick();
    n_checks++;
    if (ifc.s_awready !== 1'b1) begin
      n_errors++; $display("FAIL same_cycle_awready: got %b required 1", ifc.s_awready);
    end
    tick();
    ifc.s_awvalid = 1'b0;
    ifc.s_wvalid  = 1'b0;
    tick();
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_errors++; $display("FAIL same_cycle_set_wins: got %h required 00000001", d);
    end
    axi_write(A_SW_TRIG, 32'h2, 4'hF, r);
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_errors++; $display("FAIL swtrig_level_ignored: got %h required 00000001", d);
    end
    irq_i[0] = 1'b0;
    axi_write(A_PENDING, 32'h1, 4'hF, r);
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++; $display("FAIL edge_w1c: got %h required 00000000", d);
    end
    axi_write(A_SW_TRIG, 32'h1, 4'hF, r);
    axi_read(A_PENDING, d, r);
    n_checks++;
    if (d !== 32'h1 || irq_id_o !== 6'd1) begin
      n_errors++; $display("FAIL swtrig_edge: pending=%h id=%0d required 00000001/1", d, irq_id_o);
    end
    axi_write(A_PENDING, 32'h1, 4'hF, r);
  endtask

  task automatic test_claim();
    logic [31:0] d;
    logic [1:0]  r;
    irq_i = 7'b010_0100;
    repeat (LAT + 1) tick();
    axi_read(A_CLAIM, d, r);
    n_checks++;
    if (d !== 32'd3 || irq_id_o !== 6'd3) begin
      n_errors++; $display("FAIL claim_2_5: claim=%0d id=%0d required 3/3", d, irq_id_o);
    end
    axi_write(A_EN_CLR, 32'h04, 4'hF, r);
    m_enable = m_enable & ~32'h04;
    axi_read(A_CLAIM, d, r);
    n_checks++;
    if (d !== 32'd6 || irq_id_o !== 6'd6) begin
      n_errors++; $display("FAIL claim_after_clr: claim=%0d id=%0d required 6/6", d, irq_id_o);
    end
    axi_read(A_ENABLE, d, r);
    n_checks++;
    if (d !== m_enable) begin
      n_errors++; $display("FAIL claim_enable: got %h required %h", d, m_enable);
    end
    irq_i = '0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_random_levels();
    logic [31:0] d, pat, en, act;
    logic [1:0]  r;
    axi_write(A_MODE, 32'h0, 4'hF, r);
    m_mode = 32'h0;
    for (int it = 0; it < 10; it++) begin
      pat = $urandom & IRQ_MASK;
      en  = $urandom & IRQ_MASK;
      act = pat & en;
      irq_i = pat[NUM_IRQ-1:0];
      axi_write(A_ENABLE, en, 4'hF, r);
      m_enable = en;
      repeat (LAT + 1) tick();
      n_checks++;
      if (irq_o !== (act != 32'd0) || irq_id_o !== lowest_id(act)) begin
        n_errors++; $display("FAIL rand_irq it=%0d: irq=%b id=%0d required %b/%0d",
          it, irq_o, irq_id_o, (act != 32'd0), lowest_id(act));
      end
      axi_read(A_STATUS, d, r);
      n_checks++;
      if (d !== pat) begin
        n_errors++; $display("FAIL rand_status it=%0d: got %h required %h", it, d, pat);
      end
      axi_write(A_SW_TRIG, ~pat, 4'hF, r);
      axi_write(A_PENDING, pat, 4'hF, r);
      axi_read(A_PENDING, d, r);
      n_checks++;
      if (d !== pat) begin
        n_errors++; $display("FAIL rand_pending it=%0d: got %h required %h", it, d, pat);
      end
      axi_read(A_CLAIM, d, r);
      n_checks++;
      if (d !== 32'(lowest_id(act))) begin
        n_errors++; $display("FAIL rand_claim it=%0d: got %0d required %0d", it, d, lowest_id(act));
      end
    end
    irq_i = '0;
    axi_write(A_MODE, 32'h1, 4'hF, r);
    m_mode = 32'h1;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_protocol();
    logic [31:0] d;
    logic [1:0]  r;
    int          accepts;
    int          n;
    axi_read(8'h20, d, r);
    n_checks++;
    if (d !== 32'd0 || r !== 2'b10) begin
      n_errors++; $display("FAIL unmapped_read: rdata=%h rresp=%b required 0/10", d, r);
    end
    axi_write(8'h28, 32'hFF, 4'hF, r);
    n_checks++;
    if (r !== 2'b10) begin
      n_errors++; $display("FAIL unmapped_write: bresp=%b required 10", r);
    end
    axi_read(A_ENABLE, d, r);
    n_checks++;
    if (d !== m_enable) begin
      n_errors++; $display("FAIL unmapped_no_effect: got %h required %h", d, m_enable);
    end
    // AW three cycles ahead of W, then B held off for five cycles.
    accepts = 0;
    ifc.s_awaddr  = A_ENABLE;
    ifc.s_wdata   = 32'h55;
    ifc.s_wstrb   = 4'hF;
    ifc.s_bready  = 1'b0;
    ifc.s_awvalid = 1'b1;
    ifc.s_wvalid  = 1'b0;
    repeat (3) begin
      tick();
      if (ifc.s_awready === 1'b1) accepts++;
    end
    ifc.s_wvalid = 1'b1;
    n = 0;
    while (ifc.s_awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ifc.s_awready === 1'b1) accepts++;
    tick();
    ifc.s_awvalid = 1'b0;
    ifc.s_wvalid  = 1'b0;
    m_enable = 32'h55;
    for (int k = 0; k < 5; k++) begin
      if (ifc.s_awready === 1'b1) accepts++;
      n_checks++;
      if (ifc.s_bvalid !== 1'b1) begin
        n_errors++; $display("FAIL bvalid_hold cycle=%0d: got %b required 1", k, ifc.s_bvalid);
      end
      tick();
    end
    n_checks++;
    if (accepts !== 1) begin
      n_errors++; $display("FAIL single_accept: got %0d accepts required 1", accepts);
    end
    ifc.s_bready = 1'b1;
    tick();
    n_checks++;
    if (ifc.s_bvalid !== 1'b0) begin
      n_errors++; $display("FAIL bvalid_release: got %b required 0", ifc.s_bvalid);
    end
    axi_read(A_ENABLE, d, r);
    n_checks++;
    if (d !== m_enable) begin
      n_errors++; $display("FAIL late_w_enable: got %h required %h", d, m_enable);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    axi_write(A_MODE, 32'h7E, 4'hF, r);
    ifc.s_araddr  = A_MODE;
    ifc.s_rready  = 1'b0;
    ifc.s_arvalid = 1'b1;
    n = 0;
    while (ifc.s_arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    areset = 1'b1;
    tick();
    ifc.s_arvalid = 1'b0;
    tick();
    areset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ifc.s_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL inflight_dropped cycle=%0d: rvalid=%b required 0", k, ifc.s_rvalid);
      end
    end
    axi_read(A_MODE, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_errors++; $display("FAIL inflight_mode_reset: got %h required 00000001", d);
    end
  endtask

  initial begin
    areset        = 1'b1;
    irq_i         = '0;
    ifc.s_awaddr  = '0;
    ifc.s_awvalid = 1'b0;
    ifc.s_wdata   = 32'd0;
    ifc.s_wstrb   = 4'h0;
    ifc.s_wvalid  = 1'b0;
    ifc.s_bready  = 1'b1;
    ifc.s_araddr  = '0;
    ifc.s_arvalid = 1'b0;
    ifc.s_rready  = 1'b1;
    m_enable      = 32'd0;
    m_mode        = 32'h1;
    test_reset();
    test_reg_random();
    test_edge_pulse();
    test_level();
    test_same_cycle();
    test_claim();
    test_random_levels();
    test_protocol();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
